// File: rtl/rvc_asap_fpga_in_cond.sv
// rvc_asap_fpga_in_cond: synchronizes and debounces two buttons and ten switches, with press and change pulses
module rvc_asap_fpga_in_cond #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic       Clock,
    input  logic       Rst,
    input  logic       RawButton_0,
    input  logic       RawButton_1,
    input  logic [9:0] RawSwitch,
    output logic       Button_0,
    output logic       Button_1,
    output logic [9:0] Switch,
    output logic       Button0Press,
    output logic       Button1Press,
    output logic       SwitchChange
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [11:0] INV = {10'b0, {2{BUTTON_ACTIVE_LOW}}};
    logic [11:0] w_raw, w_n, w_commit;
    logic [11:0] r_s1, r_s, r_q;
    logic        r_b0p, r_b1p, r_swc;
    assign w_raw = {RawSwitch, RawButton_1, RawButton_0};
    assign w_n   = r_s ^ INV;
    always_ff @(posedge Clock) begin
        if (Rst) begin
            r_s1  <= INV;
            r_s   <= INV;
            r_q   <= '0;
            r_b0p <= 1'b0;
            r_b1p <= 1'b0;
            r_swc <= 1'b0;
        end else begin
            r_s1  <= w_raw;
            r_s   <= r_s1;
            r_q   <= (r_q & ~w_commit) | (w_n & w_commit);
            r_b0p <= w_commit[0] & w_n[0];
            r_b1p <= w_commit[1] & w_n[1];
            r_swc <= |w_commit[11:2];
        end
    end
    genvar c;
    generate
        for (c = 0; c < 12; c++) begin : g_ch
            logic [CW-1:0] r_cnt;
            assign w_commit[c] = (w_n[c] != r_q[c]) && (r_cnt == LAST);
            always_ff @(posedge Clock) begin
                if (Rst)
                    r_cnt <= '0;
                else
                    r_cnt <= (w_n[c] == r_q[c] || w_commit[c]) ? '0 : r_cnt + 1'b1;
            end
        end
    endgenerate
    assign Button_0     = r_q[0];
    assign Button_1     = r_q[1];
    assign Switch       = r_q[11:2];
    assign Button0Press = r_b0p;
    assign Button1Press = r_b1p;
    assign SwitchChange = r_swc;
endmodule

// File: tb/tb_rvc_asap_fpga_in_cond.sv
// tb_rvc_asap_fpga_in_cond: scoreboard bench with a window-based debounce reference model
module tb_rvc_asap_fpga_in_cond;
    localparam int D = 4;
    localparam logic [11:0] INV = 12'b0000_0000_0011;
    typedef struct { string nm; int sel; int exp; } chk_t;
    logic       Clock = 1'b0;
    logic       Rst;
    logic       rb0, rb1;
    logic [9:0] sw;
    logic       Button_0, Button_1, Button0Press, Button1Press, SwitchChange;
    logic [9:0] Switch;
    logic [14:0] sb[$];
    chk_t        chk_q[$];
    int total = 0, bad = 0;
    int n_b0 = 0, n_b1 = 0, n_sw = 0, n_all = 0;
    bit done = 1'b0;
    logic [11:0] m_s1, m_s, m_q;
    logic [11:0] win[$];

    rvc_asap_fpga_in_cond #(.DEBOUNCE_CYCLES(D), .BUTTON_ACTIVE_LOW(1'b1)) dut (
        .Clock(Clock), .Rst(Rst), .RawButton_0(rb0), .RawButton_1(rb1), .RawSwitch(sw),
        .Button_0(Button_0), .Button_1(Button_1), .Switch(Switch),
        .Button0Press(Button0Press), .Button1Press(Button1Press), .SwitchChange(SwitchChange)
    );

    always #5 Clock = ~Clock;

    // A channel commits when its last D synchronized samples all disagree with its stable value.
    always @(posedge Clock) begin
        logic [11:0] n, commit;
        logic p0, p1, pc;
        p0 = 1'b0; p1 = 1'b0; pc = 1'b0;
        if (Rst) begin
            m_s1 = INV;
            m_s  = INV;
            m_q  = '0;
            win.delete();
        end else begin
            n = m_s ^ INV;
            win.push_back(n);
            if (win.size() > D) void'(win.pop_front());
            commit = '0;
            if (win.size() == D)
                for (int c = 0; c < 12; c++) begin
                    commit[c] = 1'b1;
                    foreach (win[i]) if (win[i][c] == m_q[c]) commit[c] = 1'b0;
                end
            p0 = commit[0] & n[0];
            p1 = commit[1] & n[1];
            pc = |commit[11:2];
            m_q  = m_q ^ commit;
            m_s  = m_s1;
            m_s1 = {sw, rb1, rb0};
        end
        sb.push_back({pc, p1, p0, m_q});
    end

    always @(negedge Clock) begin
        logic [14:0] e, a;
        chk_t k;
        int v;
        a = {SwitchChange, Button1Press, Button0Press, Switch, Button_1, Button_0};
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL outputs @%0t: got %h expected %h", $time, a, e);
            end
        end
        if (Button0Press === 1'b1) n_b0++;
        if (Button1Press === 1'b1) n_b1++;
        if (SwitchChange === 1'b1) n_sw++;
        if ((Button0Press & Button1Press & SwitchChange) === 1'b1) n_all++;
        while (chk_q.size() != 0) begin
            k = chk_q.pop_front();
            v = k.sel == 0 ? n_b0 : k.sel == 1 ? n_b1 : k.sel == 2 ? n_sw :
                k.sel == 3 ? int'(Switch) : k.sel == 4 ? int'(Button_0) :
                k.sel == 5 ? int'(Button_1) : k.sel == 6 ? n_b0 + n_b1 + n_sw : n_all;
            total++;
            if (v != k.exp) begin
                bad++;
                $display("FAIL %s: got %0d expected %0d", k.nm, v, k.exp);
            end
        end
        if (done) begin
            if (sb.size() != 0) begin
                total++;
                bad++;
                $display("FAIL drain: %0d entries left", sb.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge Clock);
        #2;
    endtask

    task automatic want(string nm, int sel, int exp);
        chk_q.push_back('{nm: nm, sel: sel, exp: exp});
    endtask

    initial begin
        Rst = 1'b1; rb0 = 1'b1; rb1 = 1'b1; sw = '0;
        cyc(20);
        want("rst_sw", 3, 0); want("rst_b0", 4, 0); want("rst_b1", 5, 0); want("rst_pulses", 6, 0);
        Rst = 1'b0; rb0 = 1'b0;
        cyc(4);
        Rst = 1'b1;
        cyc(2);
        Rst = 1'b0; rb0 = 1'b1;
        cyc(12);
        want("rst_mid_pulses", 6, 0); want("rst_mid_b0", 4, 0);
        rb0 = 1'b0;
        cyc(10);
        want("b0_pressed", 4, 1); want("b0_press", 0, 1);
        rb0 = 1'b1;
        cyc(10);
        want("b0_released", 4, 0); want("b0_release_nopulse", 0, 1);
        rb1 = 1'b0; cyc(3); rb1 = 1'b1; cyc(10);
        want("b1_glitch3", 1, 0); want("b1_glitch3_lvl", 5, 0);
        rb1 = 1'b0; cyc(4); rb1 = 1'b1; cyc(12);
        want("b1_pulse4", 1, 1); want("b1_pulse4_back", 5, 0);
        sw = 10'h2A5; cyc(10);
        want("sw_2a5", 3, 'h2A5); want("sw_2a5_pulse", 2, 1);
        sw = 10'h2A4; cyc(10);
        want("sw_2a4", 3, 'h2A4); want("sw_2a4_pulse", 2, 2);
        sw = 10'h2A5; cyc(1); sw = 10'h2A4; cyc(1); sw = 10'h2A5; cyc(1); sw = 10'h2A4; cyc(1);
        sw = 10'h2A5; cyc(10);
        want("sw_bounce", 3, 'h2A5); want("sw_bounce_pulse", 2, 3);
        rb0 = 1'b0; rb1 = 1'b0; sw = 10'h155; cyc(10);
        want("both_b0", 0, 2); want("both_b1", 1, 2); want("both_sw", 2, 4); want("both_same_cycle", 7, 1);
        rb0 = 1'b1; rb1 = 1'b1; cyc(10);
        Rst = 1'b1; sw = 10'h3FF; cyc(3);
        want("rst_3ff_clear", 3, 0); want("rst_3ff_nopulse", 2, 4);
        Rst = 1'b0; cyc(5);
        want("sw_3ff_early", 3, 0);
        cyc(1);
        want("sw_3ff", 3, 'h3FF); want("sw_3ff_pulse", 2, 5);
        cyc(2);
        for (int i = 0; i < 2000; i++) begin
            Rst = ($urandom_range(0, 199) == 0);
            rb0 = rb0 ^ ($urandom_range(0, 3) == 0);
            rb1 = rb1 ^ ($urandom_range(0, 3) == 0);
            for (int b = 0; b < 10; b++) sw[b] = sw[b] ^ ($urandom_range(0, 3) == 0);
            cyc(1);
        end
        Rst = 1'b0;
        cyc(12);
        done = 1'b1;
        cyc(5);
        $display("FAIL timeout: monitor did not finish");
        $fatal(1);
    end
endmodule
